// File: rtl/regfile_pkg.sv
// Shared sizing constants for the scoreboarded register file.
package regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NREGS_DEF  = 2 ** ADDR_W_DEF;

  function automatic int nregs_of(input int addr_w);
    return 2 ** addr_w;
  endfunction
endpackage

// File: rtl/reg_scoreboard.sv
// Pending-bit tracker: one bit per register plus a running popcount.
// Lookups return the post-edge state so readers see same-cycle set/clear.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] look_a,
  input  logic [ADDR_W-1:0] look_b,
  output logic              pend_a,
  output logic              pend_b,
  output logic [ADDR_W:0]   cnt
);
  localparam int NREGS = nregs_of(ADDR_W);

  logic [NREGS-1:0] pend_reg;
  logic [NREGS-1:0] pend_next;
  logic [ADDR_W:0]  cnt_reg;
  logic [ADDR_W:0]  cnt_next;
  logic             set_v;
  logic             clr_v;
  logic             inc;
  logic             dec;

  assign set_v = set_en && (set_addr != '0);
  assign clr_v = clr_en && (clr_addr != '0);

  // Set is applied after clear, so a same-address reserve wins over a write.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_bit
    if (gi == 0) begin : g_zero
      assign pend_next[gi] = 1'b0;
    end else begin : g_reg
      assign pend_next[gi] = (pend_reg[gi] && !(clr_v && clr_addr == ADDR_W'(gi)))
                           || (set_v && set_addr == ADDR_W'(gi));
    end
  end

  assign inc = set_v && !pend_reg[set_addr];
  assign dec = clr_v && pend_reg[clr_addr] && !(set_v && set_addr == clr_addr);

  always_comb begin
    cnt_next = cnt_reg;
    if (inc && !dec) cnt_next = cnt_reg + 1'b1;
    else if (dec && !inc) cnt_next = cnt_reg - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      pend_reg <= pend_next;
      cnt_reg  <= cnt_next;
    end
  end

  assign pend_a = pend_next[look_a];
  assign pend_b = pend_next[look_b];
  assign cnt    = cnt_reg;
endmodule

// File: rtl/reg_file_sb.sv
// Two-read, one-write register file with registered reads, optional
// write-to-read forwarding and a pending-producer scoreboard.
module reg_file_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic              a_pend,
  output logic              b_pend,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W:0]   pend_cnt
);
  localparam int NREGS = nregs_of(ADDR_W);

  logic [DATA_W-1:0] mem [NREGS];
  logic [DATA_W-1:0] a_next;
  logic [DATA_W-1:0] b_next;
  logic              wr_v;
  logic              pend_a_next;
  logic              pend_b_next;

  assign wr_v = wr_en && (wr_addr != '0);

  // Entry 0 is never written, so reading it always yields zero.
  always_comb begin
    a_next = mem[ra];
    b_next = mem[rb];
    if (BYPASS != 0 && wr_v && wr_addr == ra) a_next = wr_data;
    if (BYPASS != 0 && wr_v && wr_addr == rb) b_next = wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (wr_v) begin
      mem[wr_addr] <= wr_data;
    end
  end

  reg_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (rsv_en),
    .set_addr (rsv_addr),
    .clr_en   (wr_en),
    .clr_addr (wr_addr),
    .look_a   (ra),
    .look_b   (rb),
    .pend_a   (pend_a_next),
    .pend_b   (pend_b_next),
    .cnt      (pend_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a      <= '0;
      b      <= '0;
      a_pend <= 1'b0;
      b_pend <= 1'b0;
    end else begin
      a      <= a_next;
      b      <= b_next;
      a_pend <= pend_a_next;
      b_pend <= pend_b_next;
    end
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench: directed vectors push hand-computed expectations; a
// monitor compares both BYPASS variants one cycle after each issued edge.
module tb_reg_file_sb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  ra = '0, rb = '0, rsv_addr = '0, wr_addr = '0;
  logic        rsv_en = 1'b0, wr_en = 1'b0;
  logic [31:0] wr_data = '0;

  logic [31:0] a1, b1, a0, b0;
  logic        ap1, bp1, ap0, bp0;
  logic [5:0]  cnt1, cnt0;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ap;
    logic        bp;
    logic [5:0]  cnt;
    logic [31:0] a_nobyp;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut_byp (
    .clk(clk), .rst(rst), .ra(ra), .rb(rb), .a(a1), .b(b1),
    .a_pend(ap1), .b_pend(bp1), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .pend_cnt(cnt1)
  );

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_nobyp (
    .clk(clk), .rst(rst), .ra(ra), .rb(rb), .a(a0), .b(b0),
    .a_pend(ap0), .b_pend(bp0), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .pend_cnt(cnt0)
  );

  // Monitor: every issued edge yields one response, sampled 1 ns later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        tests++;
        if (a1 !== e.a || b1 !== e.b || ap1 !== e.ap || bp1 !== e.bp ||
            cnt1 !== e.cnt || a0 !== e.a_nobyp || ap0 !== e.ap ||
            bp0 !== e.bp || cnt0 !== e.cnt) begin
          fails++;
          $display("FAIL xact t=%0t: got a=%h b=%h ap=%b bp=%b cnt=%0d a_nobyp=%h ap0=%b bp0=%b cnt0=%0d; want a=%h b=%h ap=%b bp=%b cnt=%0d a_nobyp=%h",
                   $time, a1, b1, ap1, bp1, cnt1, a0, ap0, bp0, cnt0,
                   e.a, e.b, e.ap, e.bp, e.cnt, e.a_nobyp);
        end else begin
          $display("[TB] xact t=%0t a=%h b=%h ap=%b bp=%b cnt=%0d a_nobyp=%h",
                   $time, a1, b1, ap1, bp1, cnt1, a0);
        end
      end
    end
  end

  // Drive one cycle of inputs, queue its expectation, then advance past the edge.
  task automatic cyc(input logic r_en, input logic [4:0] r_addr,
                     input logic w_en, input logic [4:0] w_addr, input logic [31:0] w_data,
                     input logic [4:0] ra_i, input logic [4:0] rb_i,
                     input logic [31:0] ea, input logic [31:0] eb,
                     input logic eap, input logic ebp, input logic [5:0] ecnt,
                     input logic [31:0] ea0);
    exp_t e;
    rsv_en = r_en; rsv_addr = r_addr;
    wr_en = w_en; wr_addr = w_addr; wr_data = w_data;
    ra = ra_i; rb = rb_i;
    e.a = ea; e.b = eb; e.ap = eap; e.bp = ebp; e.cnt = ecnt; e.a_nobyp = ea0;
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic check_zero(input string name);
    tests++;
    if (a1 !== 0 || b1 !== 0 || ap1 !== 0 || bp1 !== 0 || cnt1 !== 0 ||
        a0 !== 0 || b0 !== 0 || ap0 !== 0 || bp0 !== 0 || cnt0 !== 0) begin
      fails++;
      $display("FAIL %s: got a=%h b=%h ap=%b bp=%b cnt=%0d a0=%h b0=%h cnt0=%0d; want all zero",
               name, a1, b1, ap1, bp1, cnt1, a0, b0, cnt0);
    end else begin
      $display("[TB] %s: all outputs zero", name);
    end
  endtask

  initial begin
    int budget;
    #3;
    check_zero("reset_initial");
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst = 1'b0;

    // Every address reads zero after reset.
    for (int i = 0; i < 32; i++)
      cyc(0, 0, 0, 0, 0, 5'(i), 5'(31 - i), 0, 0, 0, 0, 0, 0);

    // Write r5 while reading it: forwarded vs pre-write value.
    cyc(0, 0, 1, 5, 32'hDEADBEEF, 5, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 0, 0, 0, 0, 32'hDEADBEEF);

    // Reserve r3, then write it.
    cyc(1, 3, 0, 0, 0, 0, 3, 0, 0, 0, 1, 1, 0);
    cyc(0, 0, 1, 3, 32'd7, 3, 3, 32'd7, 32'd7, 0, 0, 0, 0);

    // Same-cycle reserve and write to r9: reserve wins, data still lands.
    cyc(1, 9, 1, 9, 32'h1234, 9, 9, 32'h1234, 32'h1234, 1, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 9, 5, 32'h1234, 32'hDEADBEEF, 1, 0, 1, 32'h1234);

    // Reserve and write to r0 are ignored.
    cyc(1, 0, 1, 0, 32'hFFFF, 0, 0, 0, 0, 0, 0, 1, 0);

    // Write to a non-pending register leaves the count alone.
    cyc(0, 0, 1, 5, 32'hCAFEF00D, 5, 9, 32'hCAFEF00D, 32'h1234, 0, 1, 1, 32'hDEADBEEF);

    // Set r4 and clear r9 together: count unchanged.
    cyc(1, 4, 1, 9, 32'h55, 4, 9, 0, 32'h55, 1, 0, 1, 0);

    // Reserve r1..r31; r4 is already pending so it adds nothing.
    for (int i = 1; i < 32; i++)
      cyc(1, 5'(i), 0, 0, 0, 0, 4, 0, 0, 0, 1, (i < 4) ? 6'(i + 1) : 6'(i), 0);

    // Re-reserving a pending register must not wrap the count.
    cyc(1, 4, 0, 0, 0, 4, 31, 0, 0, 1, 1, 31, 0);
    cyc(0, 0, 1, 3, 32'h99, 3, 5, 32'h99, 32'hCAFEF00D, 0, 1, 30, 32'd7);

    // Reset between edges clears everything at once; strobes during reset are dropped.
    rsv_en = 1; rsv_addr = 6; wr_en = 1; wr_addr = 6; wr_data = 32'h77; ra = 6; rb = 5;
    rst = 1'b1;
    #1;
    check_zero("reset_async");
    @(posedge clk); #2;
    rsv_en = 0; wr_en = 0;
    rst = 1'b0;
    cyc(0, 0, 0, 0, 0, 6, 5, 0, 0, 0, 0, 0, 0);
    cyc(1, 7, 1, 7, 32'hA5, 7, 3, 32'hA5, 0, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 7, 0, 32'hA5, 0, 1, 0, 1, 32'hA5);

    budget = 0;
    while (q.size() != 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #3;
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, meaning the register width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 5, meaning the address width; NREGS = 2**ADDR_W registers.
REQ-003 SHALL provide parameter BYPASS, default 1, meaning 1 = same-cycle write data forwarded to reads and 0 = reads return the pre-write array value.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  in  1  sole clock; all state updates on posedge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 ra  in  ADDR_W  read port A address.
REQ-008 rb  in  ADDR_W  read port B address.
REQ-009 a  out  DATA_W  registered read data, port A.
REQ-010 b  out  DATA_W  registered read data, port B.
REQ-011 a_pend  out  1  registered flag: the port A source has an outstanding producer.
REQ-012 b_pend  out  1  registered flag: the port B source has an outstanding producer.
REQ-013 rsv_en  in  1  reserve strobe; marks rsv_addr as pending.
REQ-014 rsv_addr  in  ADDR_W  register being reserved.
REQ-015 wr_en  in  1  write strobe.
REQ-016 wr_addr  in  ADDR_W  write address.
REQ-017 wr_data  in  DATA_W  write data.
REQ-018 pend_cnt  out  ADDR_W+1  number of registers currently pending.

Function
REQ-019 Register 0 SHALL read as 0 and never pend; writes and reserves to address 0 SHALL be ignored.
REQ-020 Write: on posedge with wr_en=1 and wr_addr!=0, the array SHALL store wr_data and clear pending[wr_addr].
REQ-021 Reserve: on posedge with rsv_en=1 and rsv_addr!=0, the block SHALL set pending[rsv_addr].
REQ-022 Reserve and write to the same address in the same cycle: reserve SHALL win, so pending ends set and the data is still written.
REQ-023 Reserve of an already-pending register SHALL leave the bit set and pend_cnt unchanged.
REQ-024 A write to a non-pending register SHALL be legal and SHALL leave pend_cnt unchanged.
REQ-025 Read latency SHALL be 1 cycle: a/b update on every posedge from the ra/rb values sampled at that edge, with no enable.
REQ-026 If BYPASS=1 and wr_en=1 and wr_addr==ra (ra!=0), a SHALL equal wr_data; port B SHALL behave the same way.
REQ-027 If BYPASS=0, a/b SHALL return the array contents from before the same-edge write.
REQ-028 a_pend/b_pend SHALL reflect the post-edge pending state, i.e. include same-cycle clear by write and same-cycle set by reserve.
REQ-029 pend_cnt SHALL equal the popcount of the pending bits at all times: +1 on a set of a clear bit, -1 on a clear of a set bit, unchanged when both happen on different addresses.
REQ-030 pend_cnt SHALL NOT wrap; its maximum value is NREGS-1.

Reset
REQ-031 rst=1 SHALL immediately clear all array entries, all pending bits, a, b, a_pend, b_pend and pend_cnt to 0, independent of clk.
REQ-032 A reserve or write coincident with reset assertion SHALL be discarded.
REQ-033 The first posedge after reset deassertion SHALL operate normally.

Structure
REQ-034 Package regfile_pkg SHALL hold the DATA_W/ADDR_W defaults and the derived NREGS constant.
REQ-035 Pending-bit tracking and pend_cnt SHALL be a sub-module reg_scoreboard (set, clear and lookup ports for A and B).
REQ-036 The array SHALL have no read-enable, and its reads SHALL be inferred from posedge logic only.

Verification
REQ-037 Reset, then reads of every address -> a=b=0, pends=0, pend_cnt=0.
REQ-038 Write r5=0xDEADBEEF with ra=5 in the same cycle, BYPASS=1 -> a=0xDEADBEEF next cycle; BYPASS=0 -> a=0, then 0xDEADBEEF one cycle later.
REQ-039 Reserve r3, read rb=3 -> b_pend=1, pend_cnt=1; write r3=7 -> b=7, b_pend=0, pend_cnt=0.
REQ-040 Same-cycle reserve and write to r9 -> r9 data written, pending remains 1, pend_cnt=1; reserve and write to r0 -> no change.
REQ-041 Reserve r1..r31 over 31 cycles, then reserve r4 again -> pend_cnt=31 with no wrap.
REQ-042 Assert rst mid-sequence between edges -> all outputs 0 at once.
